// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Core request/response and word-memory port bundle for mem_access_unit.
// Revision : 1.0
// ============================================================================
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    i_valid;
  logic                    o_ready;
  logic                    i_we;
  logic [1:0]              i_size;
  logic                    i_unsigned;
  logic [ADDR_WIDTH+1:0]   i_addr;
  logic [DATA_WIDTH-1:0]   i_wdata;
  logic                    o_done;
  logic [DATA_WIDTH-1:0]   o_rdata;
  logic                    o_misaligned;
  logic [ADDR_WIDTH-1:0]   o_mem_address;
  logic                    o_mem_wenable;
  logic [DATA_WIDTH-1:0]   o_mem_wdata;
  logic [DATA_WIDTH-1:0]   i_mem_data;

  modport slave (
    input  i_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_data,
    output o_ready, o_done, o_rdata, o_misaligned,
    output o_mem_address, o_mem_wenable, o_mem_wdata
  );

  modport master (
    output i_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_data,
    input  o_ready, o_done, o_rdata, o_misaligned,
    input  o_mem_address, o_mem_wenable, o_mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Byte/halfword/word load-store initiator with read-modify-write stores.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_we, w_we_nxt;
  logic [1:0]              r_size, w_size_nxt;
  logic                    r_unsigned, w_unsigned_nxt;
  logic [1:0]              r_lane, w_lane_nxt;
  logic [15:0]             r_wdata_lo, w_wdata_lo_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_misaligned, w_misaligned_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic [ADDR_WIDTH-1:0]   r_mem_address, w_mem_address_nxt;
  logic                    r_mem_wenable, w_mem_wenable_nxt;
  // Serves both as the read-modify-write merge register and the write-data output.
  logic [DATA_WIDTH-1:0]   r_wword, w_wword_nxt;

  logic                    w_bad_align;
  logic [DATA_WIDTH-1:0]   w_rd_lanes;
  logic [4:0]              w_shamt;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]   w_load;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]   w_ins;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_bad_align = (bus.i_size == 2'b11)
                     | ((bus.i_size == c_SZ_HALF) & bus.i_addr[0])
                     | ((bus.i_size == c_SZ_WORD) & (bus.i_addr[1:0] != 2'b00));

  // Memory returns lane 0 in the top byte; flip it into lane k at bits [8k+7:8k].
  assign w_rd_lanes = {bus.i_mem_data[7:0],   bus.i_mem_data[15:8],
                       bus.i_mem_data[23:16], bus.i_mem_data[31:24]};

  assign w_shamt   = {r_lane, 3'b000};
  assign w_shifted = w_rd_lanes >> w_shamt;

  always_comb begin
    w_load = w_rd_lanes;
    case (r_size)
      c_SZ_BYTE: w_load = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      c_SZ_HALF: w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default:   w_load = w_rd_lanes;
    endcase
  end

  assign w_mask   = ((r_size == c_SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
  assign w_ins    = {16'h0000, r_wdata_lo} << w_shamt;
  assign w_merged = (w_rd_lanes & ~w_mask) | (w_ins & w_mask);

  always_comb begin
    w_state_nxt       = r_state;
    w_we_nxt          = r_we;
    w_size_nxt        = r_size;
    w_unsigned_nxt    = r_unsigned;
    w_lane_nxt        = r_lane;
    w_wdata_lo_nxt    = r_wdata_lo;
    w_done_nxt        = 1'b0;
    w_misaligned_nxt  = 1'b0;
    w_rdata_nxt       = r_rdata;
    w_mem_address_nxt = r_mem_address;
    w_mem_wenable_nxt = 1'b0;
    w_wword_nxt       = r_wword;

    case (r_state)
      S_IDLE: begin
        if (bus.i_valid) begin
          w_we_nxt       = bus.i_we;
          w_size_nxt     = bus.i_size;
          w_unsigned_nxt = bus.i_unsigned;
          w_lane_nxt     = bus.i_addr[1:0];
          w_wdata_lo_nxt = bus.i_wdata[15:0];
          if (w_bad_align) begin
            w_done_nxt       = 1'b1;
            w_misaligned_nxt = 1'b1;
          end else begin
            w_state_nxt       = S_ACCESS;
            w_mem_address_nxt = bus.i_addr[ADDR_WIDTH+1:2];
            if (bus.i_we && (bus.i_size == c_SZ_WORD)) begin
              w_mem_wenable_nxt = 1'b1;
              w_wword_nxt       = bus.i_wdata;
            end
          end
        end
      end
      S_ACCESS: begin
        if (!r_we) begin
          w_rdata_nxt = w_load;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_size == c_SZ_WORD) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wword_nxt       = w_merged;
          w_mem_wenable_nxt = 1'b1;
          w_state_nxt       = S_WRITE;
        end
      end
      S_WRITE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_size        <= 2'b00;
      r_unsigned    <= 1'b0;
      r_lane        <= 2'b00;
      r_wdata_lo    <= 16'h0000;
      r_done        <= 1'b0;
      r_misaligned  <= 1'b0;
      r_rdata       <= '0;
      r_mem_address <= '0;
      r_mem_wenable <= 1'b0;
      r_wword       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_we          <= w_we_nxt;
      r_size        <= w_size_nxt;
      r_unsigned    <= w_unsigned_nxt;
      r_lane        <= w_lane_nxt;
      r_wdata_lo    <= w_wdata_lo_nxt;
      r_done        <= w_done_nxt;
      r_misaligned  <= w_misaligned_nxt;
      r_rdata       <= w_rdata_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wenable <= w_mem_wenable_nxt;
      r_wword       <= w_wword_nxt;
    end
  end

  assign bus.o_ready       = (r_state == S_IDLE);
  assign bus.o_done        = r_done;
  assign bus.o_misaligned  = r_misaligned;
  assign bus.o_rdata       = r_rdata;
  assign bus.o_mem_address = r_mem_address;
  assign bus.o_mem_wenable = r_mem_wenable;
  assign bus.o_mem_wdata   = r_wword;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed scoreboard bench for mem_access_unit with a byte-reversing memory.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

  localparam logic [1:0] c_B = 2'b00;
  localparam logic [1:0] c_H = 2'b01;
  localparam logic [1:0] c_W = 2'b10;

  typedef struct {
    string       tag;
    logic        is_load;
    logic        mis;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   last_wr = -1;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [31:0] w_word;

  mem_access_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: writes in lane order, reads back byte-reversed.
  assign w_word         = mem[bus.o_mem_address];
  assign bus.i_mem_data = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_mem_wenable === 1'b1) begin
      mem[bus.o_mem_address] <= bus.o_mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wr <= cyc + 1;
    end
    if (rst_n && bus.i_valid && bus.o_ready) acc_edge <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_done === 1'b1) begin
      done_cnt++;
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_mis"}, 32'(bus.o_misaligned), 32'(mon_e.mis));
        if (mon_e.is_load && !mon_e.mis) chk({mon_e.tag, "_rdata"}, bus.o_rdata, mon_e.rdata);
        chk({mon_e.tag, "_lat"}, cyc - acc_edge, mon_e.lat);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata, input string tag,
                       input logic [31:0] exp_rdata, input logic exp_mis, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.i_valid    = 1'b1;
    bus.i_we       = we;
    bus.i_size     = size;
    bus.i_unsigned = uns;
    bus.i_addr     = addr;
    bus.i_wdata    = wdata;
    e.tag = tag; e.is_load = ~we; e.mis = exp_mis; e.rdata = exp_rdata; e.lat = lat;
    sb.push_back(e);
    n = 0;
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.o_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 50), 32'd1);
  endtask

  int wc;
  int dc;

  initial begin
    rst_n          = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_we       = 1'b0;
    bus.i_size     = 2'b00;
    bus.i_unsigned = 1'b0;
    bus.i_addr     = '0;
    bus.i_wdata    = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_wen", 32'(bus.o_mem_wenable), 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'h0);
    chk("rst_addr", 32'(bus.o_mem_address), 32'h0);
    chk("rst_wdata", bus.o_mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", 32'(bus.o_ready), 32'd1);

    // Word store then word load
    issue(1'b1, c_W, 1'b0, 10'h00C, 32'h1122_3344, "wst", 32'h0, 1'b0, 1);
    wait_idle("wst");
    chk("wst_wedge", last_wr - acc_edge, 32'd1);
    chk("wst_mem", mem[3], 32'h1122_3344);
    issue(1'b0, c_W, 1'b0, 10'h00C, 32'h0, "wld1", 32'h1122_3344, 1'b0, 1);
    issue(1'b0, c_B, 1'b0, 10'h00D, 32'h0, "bld_d", 32'h0000_0033, 1'b0, 1);
    wait_idle("ld1");

    // Byte read-modify-write store
    wc = wr_cnt;
    issue(1'b1, c_B, 1'b0, 10'h00E, 32'hABCD_EF9A, "bst", 32'h0, 1'b0, 2);
    wait_idle("bst");
    chk("bst_wedge", last_wr - acc_edge, 32'd2);
    chk("bst_wcnt", wr_cnt - wc, 32'd1);
    chk("bst_mem", mem[3], 32'h119A_3344);
    issue(1'b0, c_B, 1'b0, 10'h00E, 32'h0, "bld_e", 32'hFFFF_FF9A, 1'b0, 1);
    issue(1'b0, c_W, 1'b0, 10'h00C, 32'h0, "wld2", 32'h119A_3344, 1'b0, 1);
    issue(1'b0, c_H, 1'b1, 10'h00E, 32'h0, "hld_u", 32'h0000_119A, 1'b0, 1);
    issue(1'b0, c_H, 1'b0, 10'h00E, 32'h0, "hld_s", 32'h0000_119A, 1'b0, 1);
    wait_idle("ld2");

    // Halfword store and sign checks
    issue(1'b1, c_H, 1'b0, 10'h00C, 32'h1234_8001, "hst", 32'h0, 1'b0, 2);
    issue(1'b0, c_H, 1'b0, 10'h00C, 32'h0, "hld_c", 32'hFFFF_8001, 1'b0, 1);
    issue(1'b0, c_B, 1'b1, 10'h00D, 32'h0, "bld_du", 32'h0000_0080, 1'b0, 1);
    issue(1'b0, c_B, 1'b0, 10'h00D, 32'h0, "bld_ds", 32'hFFFF_FF80, 1'b0, 1);
    wait_idle("hst");
    chk("hst_mem", mem[3], 32'h119A_8001);
    chk("addr_hold", 32'(bus.o_mem_address), 32'd3);

    // Misaligned requests never touch memory
    wc = wr_cnt;
    issue(1'b1, c_H, 1'b0, 10'h00D, 32'hDEAD_BEEF, "mis_h", 32'h0, 1'b1, 0);
    issue(1'b1, c_W, 1'b0, 10'h00E, 32'hDEAD_BEEF, "mis_w", 32'h0, 1'b1, 0);
    issue(1'b1, 2'b11, 1'b0, 10'h00C, 32'hDEAD_BEEF, "mis_s", 32'h0, 1'b1, 0);
    issue(1'b0, 2'b11, 1'b0, 10'h00C, 32'h0, "mis_l", 32'h0, 1'b1, 0);
    wait_idle("mis");
    chk("mis_wcnt", wr_cnt - wc, 32'd0);
    chk("mis_mem", mem[3], 32'h119A_8001);

    // Reset during the WRITE phase of a byte store
    wc = wr_cnt;
    dc = done_cnt;
    issue(1'b1, c_B, 1'b0, 10'h00F, 32'h0000_0055, "abort", 32'h0, 1'b0, 2);
    @(negedge clk);
    @(negedge clk);
    chk("abort_inwrite", 32'(bus.o_mem_wenable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wen", 32'(bus.o_mem_wenable), 32'd0);
    chk("abort_done", 32'(bus.o_done), 32'd0);
    chk("abort_mis", 32'(bus.o_misaligned), 32'd0);
    chk("abort_rdata", bus.o_rdata, 32'h0);
    chk("abort_addr", 32'(bus.o_mem_address), 32'h0);
    chk("abort_wdata", bus.o_mem_wdata, 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_ready", 32'(bus.o_ready), 32'd1);
    chk("abort_wcnt", wr_cnt - wc, 32'd0);
    chk("abort_mem", mem[3], 32'h119A_8001);
    chk("abort_nodone", done_cnt - dc, 32'd0);

    // Back-to-back loads after reset
    dc = done_cnt;
    issue(1'b0, c_W, 1'b0, 10'h00C, 32'h0, "b2b_w", 32'h119A_8001, 1'b0, 1);
    issue(1'b0, c_B, 1'b1, 10'h00F, 32'h0, "b2b_b", 32'h0000_0011, 1'b0, 1);
    issue(1'b0, c_H, 1'b0, 10'h00C, 32'h0, "b2b_h", 32'hFFFF_8001, 1'b0, 1);
    wait_idle("b2b");
    @(negedge clk);
    chk("b2b_dones", done_cnt - dc, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
